// File: rtl/ats21_cmd_issuer.sv
// Two-client command issuer for ATS21: per-client 2-deep FIFOs feeding a HI/LO/GAP word sequencer.
// Optional build macro ATS21_OPCODE_CHECK_EN discards opcodes 3'b000/3'b100 and pulses drop_err.
module ats21_cmd_issuer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [31:0] a_instr,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_instr,
    output logic        b_ready,
    input  logic        ats_ready,
    output logic        req,
    output logic [15:0] ctrlA,
    output logic [15:0] ctrlB,
    output logic        busy,
    output logic        drop_err
);

    typedef enum logic [1:0] {IDLE, HI, LO, GAP} state_t;

    state_t      state_q, state_d;

    logic [31:0] fifo_a [2];
    logic [31:0] fifo_b [2];
    logic        wr_a, rd_a, wr_b, rd_b;
    logic [1:0]  cnt_a, cnt_b, cnt_a_d, cnt_b_d;

    logic [31:0] hold_a_q, hold_b_q, hold_a_d, hold_b_d;
    logic [15:0] ctrl_a_d, ctrl_b_d;

    logic        drop_a, drop_b;
    logic        push_a, push_b, pop_a, pop_b, issue;

`ifdef ATS21_OPCODE_CHECK_EN
    function automatic logic is_dropped(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b100);
    endfunction

    assign drop_a = a_valid && a_ready && is_dropped(a_instr[31:29]);
    assign drop_b = b_valid && b_ready && is_dropped(b_instr[31:29]);

    // Both clients dropping on the same edge still yields a single pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_err <= 1'b0;
        else          drop_err <= drop_a || drop_b;
    end
`else
    assign drop_a   = 1'b0;
    assign drop_b   = 1'b0;
    assign drop_err = 1'b0;
`endif

    assign push_a = a_valid && a_ready && !drop_a;
    assign push_b = b_valid && b_ready && !drop_b;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        ctrl_a_d = 16'h0;
        ctrl_b_d = 16'h0;
        issue    = 1'b0;
        pop_a    = 1'b0;
        pop_b    = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                issue   = ats_ready && ((cnt_a != 2'd0) || (cnt_b != 2'd0));
                state_d = issue ? HI : IDLE;
            end
            HI:      state_d = LO;
            LO:      state_d = GAP;
            default: state_d = IDLE;
        endcase

        // An empty client is issued as a Nop alongside the busy one.
        if (issue) begin
            pop_a    = (cnt_a != 2'd0);
            pop_b    = (cnt_b != 2'd0);
            hold_a_d = pop_a ? fifo_a[rd_a] : 32'h0;
            hold_b_d = pop_b ? fifo_b[rd_b] : 32'h0;
        end

        case (state_d)
            HI: begin
                ctrl_a_d = hold_a_d[31:16];
                ctrl_b_d = hold_b_d[31:16];
            end
            LO: begin
                ctrl_a_d = hold_a_d[15:0];
                ctrl_b_d = hold_b_d[15:0];
            end
            default: ;
        endcase

        cnt_a_d = cnt_a + {1'b0, push_a} - {1'b0, pop_a};
        cnt_b_d = cnt_b + {1'b0, push_b} - {1'b0, pop_b};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_a     <= 1'b0;
            rd_a     <= 1'b0;
            wr_b     <= 1'b0;
            rd_b     <= 1'b0;
            cnt_a    <= 2'd0;
            cnt_b    <= 2'd0;
            hold_a_q <= 32'h0;
            hold_b_q <= 32'h0;
            req      <= 1'b0;
            ctrlA    <= 16'h0;
            ctrlB    <= 16'h0;
            busy     <= 1'b0;
            a_ready  <= 1'b1;
            b_ready  <= 1'b1;
        end else begin
            if (push_a) wr_a <= ~wr_a;
            if (pop_a)  rd_a <= ~rd_a;
            if (push_b) wr_b <= ~wr_b;
            if (pop_b)  rd_b <= ~rd_b;
            cnt_a    <= cnt_a_d;
            cnt_b    <= cnt_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            req      <= (state_d == HI);
            ctrlA    <= ctrl_a_d;
            ctrlB    <= ctrl_b_d;
            busy     <= (state_d != IDLE) || (cnt_a_d != 2'd0) || (cnt_b_d != 2'd0);
            a_ready  <= (cnt_a_d != 2'd2);
            b_ready  <= (cnt_b_d != 2'd2);
        end
    end

    // NOTE: FIFO storage is not reset; the counters alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_a) fifo_a[wr_a] <= a_instr;
        if (push_b) fifo_b[wr_b] <= b_instr;
    end

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Self-checking bench for ats21_cmd_issuer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the issue rules.
module tb_ats21_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, ats_ready = 1'b0;
    logic [31:0] a_instr = 32'h0, b_instr = 32'h0;
    logic        a_ready, b_ready, req, busy, drop_err;
    logic [15:0] ctrlA, ctrlB;

    ats21_cmd_issuer dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
        .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
        .ats_ready(ats_ready), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending instructions per client, plus edges elapsed since the last issue
    // (0 = high word on the bus, 1 = low word, 2 = spacer, 3 = nothing in flight).
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          since = 3;
    logic [31:0] ha = 32'h0, hb = 32'h0;
    logic        exp_drop = 1'b0;

    function automatic logic is_bad(input logic [31:0] instr);
`ifdef ATS21_OPCODE_CHECK_EN
        return (instr[31:29] == 3'b000) || (instr[31:29] == 3'b100);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        since    = 3;
        ha       = 32'h0;
        hb       = 32'h0;
        exp_drop = 1'b0;
    endtask

    task automatic model_step();
        logic acc_a, acc_b, go;
        acc_a = a_valid && (qa.size() < 2);
        acc_b = b_valid && (qb.size() < 2);
        go    = (since >= 2) && ats_ready && (qa.size() > 0 || qb.size() > 0);
        if (go) begin
            ha = 32'h0;
            hb = 32'h0;
            if (qa.size() > 0) ha = qa.pop_front();
            if (qb.size() > 0) hb = qb.pop_front();
            since = 0;
        end else if (since < 3) begin
            since++;
        end
        exp_drop = (acc_a && is_bad(a_instr)) || (acc_b && is_bad(b_instr));
        if (acc_a && !is_bad(a_instr)) qa.push_back(a_instr);
        if (acc_b && !is_bad(b_instr)) qb.push_back(b_instr);
    endtask

    function automatic logic [15:0] word_of(input logic [31:0] h);
        if (since == 0) return h[31:16];
        if (since == 1) return h[15:0];
        return 16'h0;
    endfunction

    task automatic check_outputs();
        check("req",      req,      since == 0);
        check("ctrlA",    ctrlA,    word_of(ha));
        check("ctrlB",    ctrlB,    word_of(hb));
        check("a_ready",  a_ready,  qa.size() < 2);
        check("b_ready",  b_ready,  qb.size() < 2);
        check("busy",     busy,     (since <= 2) || qa.size() > 0 || qb.size() > 0);
        check("drop_err", drop_err, exp_drop);
    endtask

    // Drive inputs (caller is just after a falling edge), clock once, compare at the next falling edge.
    task automatic cycle(input logic av, input logic [31:0] ai,
                         input logic bv, input logic [31:0] bi, input logic ar);
        a_valid   = av;
        a_instr   = ai;
        b_valid   = bv;
        b_instr   = bi;
        ats_ready = ar;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Asynchronous reset applied between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_req"},     req,     1'b0);
        check({tag, "_ctrlA"},   ctrlA,   16'h0);
        check({tag, "_ctrlB"},   ctrlB,   16'h0);
        check({tag, "_a_ready"}, a_ready, 1'b1);
        check({tag, "_busy"},    busy,    1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 3) == 0) x[31:29] = $urandom_range(0, 1) ? 3'b000 : 3'b100;
        return x;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req",     req,      1'b0);
        check("rst_a_ready", a_ready,  1'b1);
        check("rst_b_ready", b_ready,  1'b1);
        check("rst_busy",    busy,     1'b0);
        check("rst_drop",    drop_err, 1'b0);
        reset_n = 1'b1;

        // Single issue from A; B idle issues as a Nop.
        cycle(1'b1, 32'h2200_0000, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("single_hi_req",   req,   1'b1);
        check("single_hi_ctrlA", ctrlA, 16'h2200);
        check("single_hi_ctrlB", ctrlB, 16'h0000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("single_lo_req",   req,   1'b0);
        check("single_lo_ctrlA", ctrlA, 16'h0000);
        idle(2);

        // Both clients pending are paired in one request.
        cycle(1'b1, 32'hA080_0090, 1'b1, 32'hAE00_0090, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("pair_hi_ctrlA", ctrlA, 16'hA080);
        check("pair_hi_ctrlB", ctrlB, 16'hAE00);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("pair_lo_ctrlA", ctrlA, 16'h0090);
        check("pair_lo_ctrlB", ctrlB, 16'h0090);
        idle(2);

        // Backpressure: third push refused, then two issues in order, 3 cycles apart.
        cycle(1'b1, 32'h2111_1111, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h4222_2222, 1'b0, 32'h0, 1'b0);
        check("bp_full", a_ready, 1'b0);
        cycle(1'b1, 32'h6333_3333, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("bp_first", ctrlA, 16'h2111);
        idle(2);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("bp_second_req", req,   1'b1);
        check("bp_second",     ctrlA, 16'h4222);
        idle(4);

        // Reset during the low word, with one more entry still queued.
        cycle(1'b1, 32'h2ABC_DEF0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h2555_0000, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("mid_lo_ctrlA", ctrlA, 16'hDEF0);
        async_reset("mid");
        idle(5);

        // Opcode 3'b100: dropped with a pulse when checking is enabled, issued otherwise.
        cycle(1'b1, 32'h8000_1234, 1'b0, 32'h0, 1'b1);
`ifdef ATS21_OPCODE_CHECK_EN
        check("op_drop", drop_err, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("op_no_req",  req,      1'b0);
        check("op_drop_1c", drop_err, 1'b0);
`else
        check("op_drop", drop_err, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("op_hi", ctrlA, 16'h8000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("op_lo", ctrlA, 16'h1234);
`endif
        idle(4);

        // One entry queued while in the spacer state; push and pop on the same edge.
        cycle(1'b1, 32'h2000_0001, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h2000_0002, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h2000_0003, 1'b0, 32'h0, 1'b1);
        check("pp_ready", a_ready, 1'b1);
        check("pp_busy",  busy,    1'b1);
        idle(8);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
            cycle(1'($urandom_range(0, 1)), rand_instr(),
                  1'($urandom_range(0, 1)), rand_instr(),
                  1'($urandom_range(0, 3) != 0));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
